// File: rtl/imem_loader_pkg.sv
// riscv_pkg: opcode constants shared with decode, plus loader state and error encodings
package riscv_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} ld_state_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_OPCODE = 2'b01,
        ERR_TRUNC  = 2'b10,
        ERR_OVF    = 2'b11
    } ld_err_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input handshake and instruction-memory write port
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_opcode_legal.sv
// opcode_legal: flags whether a 7-bit major opcode belongs to the supported instruction set
module opcode_legal
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       legal
);
    assign legal = opcode inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                                  OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM};
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs little-endian bytes into instruction words, writes them to imem, then releases the core
module imem_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    imem_loader_if.slave    bus,
    output logic            cpu_rst_n,
    output logic            busy,
    output logic            done,
    output logic [1:0]      err_code,
    output logic [ADDR_W:0] word_count
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   FULL = {1'b1, {ADDR_W{1'b0}}};

    ld_state_t         state;
    ld_err_t           err_q;
    ld_err_t           fault;
    logic [1:0]        idx;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   cnt;
    logic              last_q;
    logic              ready_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic              cpu_run_q;
    logic              legal;

    opcode_legal u_legal (.opcode(wdata[6:0]), .legal(legal));

    // classify the byte being accepted: early in_last truncates, the closing byte checks opcode then capacity
    always_comb begin
        fault = idx != 2'd3 ? (bus.in_last ? ERR_TRUNC : ERR_NONE) :
                !legal      ? ERR_OPCODE :
                cnt == FULL ? ERR_OVF : ERR_NONE;
    end

    // loader FSM; handshake and status outputs are registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            err_q     <= ERR_NONE;
            idx       <= 2'd0;
            wdata     <= 32'd0;
            addr      <= BASE;
            cnt       <= '0;
            last_q    <= 1'b0;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cpu_run_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= LOAD;
                        err_q     <= ERR_NONE;
                        idx       <= 2'd0;
                        addr      <= BASE;
                        cnt       <= '0;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        cpu_run_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        wdata[{idx, 3'b000} +: 8] <= bus.in_data;
                        idx <= idx + 2'd1;
                        if (fault != ERR_NONE) begin
                            state   <= ERR;
                            err_q   <= fault;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end else if (idx == 2'd3) begin
                            state   <= WRITE;
                            we_q    <= 1'b1;
                            ready_q <= 1'b0;
                            last_q  <= bus.in_last;
                        end
                    end
                end
                WRITE: begin
                    state     <= last_q ? DONE : LOAD;
                    we_q      <= 1'b0;
                    addr      <= addr + ADDR_W'(1);
                    cnt       <= cnt + (ADDR_W + 1)'(1);
                    ready_q   <= !last_q;
                    busy_q    <= !last_q;
                    done_q    <= last_q;
                    cpu_run_q <= last_q;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr;
    assign bus.imem_wdata = wdata;
    assign cpu_rst_n      = cpu_run_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_code       = err_q;
    assign word_count     = cnt;
endmodule
